// File: rtl/fft_peak_analyzer.sv
// FFT peak analyzer: scans a captured 16-bin frame one bin per cycle and reports
// the bin with the largest magnitude squared on freq, with a one-cycle done pulse.
// One extra frame can wait in a pending buffer while the current frame is scanned.
module fft_peak_analyzer #(
   parameter int DW      = 16,
   parameter int NBIN    = 16,
   parameter bit SKIP_DC = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fft_valid,
   input  logic [2*DW-1:0] fft_d0,
   input  logic [2*DW-1:0] fft_d1,
   input  logic [2*DW-1:0] fft_d2,
   input  logic [2*DW-1:0] fft_d3,
   input  logic [2*DW-1:0] fft_d4,
   input  logic [2*DW-1:0] fft_d5,
   input  logic [2*DW-1:0] fft_d6,
   input  logic [2*DW-1:0] fft_d7,
   input  logic [2*DW-1:0] fft_d8,
   input  logic [2*DW-1:0] fft_d9,
   input  logic [2*DW-1:0] fft_d10,
   input  logic [2*DW-1:0] fft_d11,
   input  logic [2*DW-1:0] fft_d12,
   input  logic [2*DW-1:0] fft_d13,
   input  logic [2*DW-1:0] fft_d14,
   input  logic [2*DW-1:0] fft_d15,
   output logic            done,
   output logic [3:0]      freq,
   output logic            busy,
   output logic            ovf
);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   // With the DC bin excluded, bin 1 is the first one allowed to seed the best value.
   localparam logic [3:0] FIRST_IDX = SKIP_DC ? 4'd1 : 4'd0;

   state_t            r_state;
   state_t            w_state_next;
   logic [2*DW-1:0]   w_in [0:NBIN-1];
   logic [2*DW-1:0]   r_wb [0:NBIN-1];
   logic [2*DW-1:0]   r_pb [0:NBIN-1];
   logic              r_pending_v;
   logic [3:0]        r_idx;
   logic [2*DW:0]     r_best_mag;
   logic [3:0]        r_best_idx;
   logic              r_done;
   logic [3:0]        r_freq;
   logic              r_ovf;

   logic              w_load_in;   // working buffer takes the live inputs
   logic              w_load_pb;   // working buffer takes the pending frame
   logic              w_pend_in;   // pending buffer takes the live inputs
   logic              w_last;
   logic signed [DW-1:0]   w_re;
   logic signed [DW-1:0]   w_im;
   logic signed [2*DW-1:0] w_re_sq;
   logic signed [2*DW-1:0] w_im_sq;
   logic [2*DW:0]     w_mag;
   logic              w_elig;
   logic              w_take;
   logic [3:0]        w_final_idx;

   assign w_in[0]  = fft_d0;
   assign w_in[1]  = fft_d1;
   assign w_in[2]  = fft_d2;
   assign w_in[3]  = fft_d3;
   assign w_in[4]  = fft_d4;
   assign w_in[5]  = fft_d5;
   assign w_in[6]  = fft_d6;
   assign w_in[7]  = fft_d7;
   assign w_in[8]  = fft_d8;
   assign w_in[9]  = fft_d9;
   assign w_in[10] = fft_d10;
   assign w_in[11] = fft_d11;
   assign w_in[12] = fft_d12;
   assign w_in[13] = fft_d13;
   assign w_in[14] = fft_d14;
   assign w_in[15] = fft_d15;

   // Squares are non-negative, so zero-extending each to 33 bits keeps the
   // worst case (-32768, -32768) = 2^31 exact.
   assign w_re        = r_wb[r_idx][2*DW-1:DW];
   assign w_im        = r_wb[r_idx][DW-1:0];
   assign w_re_sq     = w_re * w_re;
   assign w_im_sq     = w_im * w_im;
   assign w_mag       = {1'b0, w_re_sq} + {1'b0, w_im_sq};
   assign w_elig      = !SKIP_DC || (r_idx != 4'd0);
   assign w_take      = w_elig && ((r_idx == FIRST_IDX) || (w_mag > r_best_mag));
   assign w_final_idx = w_take ? r_idx : r_best_idx;
   assign w_last      = (r_state == SCAN) && (r_idx == 4'd15);

   assign done = r_done;
   assign freq = r_freq;
   assign ovf  = r_ovf;
   assign busy = (r_state == SCAN) | r_pending_v;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state and buffer steering decisions.
   always_comb begin
      w_state_next = r_state;
      w_load_in    = 1'b0;
      w_load_pb    = 1'b0;
      w_pend_in    = 1'b0;
      case (r_state)
         IDLE: begin
            if (fft_valid) begin
               w_load_in    = 1'b1;
               w_state_next = SCAN;
            end
         end
         SCAN: begin
            if (r_idx == 4'd15) begin
               if (fft_valid && r_pending_v) begin
                  // Older pending frame goes first; the new one takes its slot.
                  w_load_pb = 1'b1;
                  w_pend_in = 1'b1;
               end else if (fft_valid) begin
                  w_load_in = 1'b1;
               end else if (r_pending_v) begin
                  w_load_pb = 1'b1;
               end else begin
                  w_state_next = IDLE;
               end
            end else if (fft_valid) begin
               w_pend_in = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Scan counter, running best, result registers and pending/overflow flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx       <= 4'd0;
         r_best_mag  <= '0;
         r_best_idx  <= 4'd0;
         r_done      <= 1'b0;
         r_freq      <= 4'd0;
         r_pending_v <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_last) r_freq <= w_final_idx;

         if (w_load_in || w_load_pb || w_last) begin
            r_idx      <= 4'd0;
            r_best_mag <= '0;
            r_best_idx <= 4'd0;
         end else if (r_state == SCAN) begin
            if (w_take) begin
               r_best_mag <= w_mag;
               r_best_idx <= r_idx;
            end
            r_idx <= r_idx + 4'd1;
         end

         if (w_pend_in) begin
            r_pending_v <= 1'b1;
            if (r_pending_v && !w_load_pb) r_ovf <= 1'b1;
         end else if (w_load_pb) begin
            r_pending_v <= 1'b0;
         end
      end
   end

   // Frame storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NBIN; i++) begin
         if (w_load_in)      r_wb[i] <= w_in[i];
         else if (w_load_pb) r_wb[i] <= r_pb[i];
         if (w_pend_in)      r_pb[i] <= w_in[i];
      end
   end

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Directed testbench for fft_peak_analyzer: one instance with the DC bin searched,
// one with it skipped, both fed the same frames.
module tb_fft_peak_analyzer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fft_valid;
   logic [31:0] d  [16];
   logic [31:0] fr [16];
   logic        done0, busy0, ovf0;
   logic [3:0]  freq0;
   logic        done1, busy1, ovf1;
   logic [3:0]  freq1;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   fft_peak_analyzer #(.DW(16), .NBIN(16), .SKIP_DC(1'b0)) dut0 (
      .clk(clk), .rst(rst), .fft_valid(fft_valid),
      .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
      .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
      .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
      .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
      .done(done0), .freq(freq0), .busy(busy0), .ovf(ovf0)
   );

   fft_peak_analyzer #(.DW(16), .NBIN(16), .SKIP_DC(1'b1)) dut1 (
      .clk(clk), .rst(rst), .fft_valid(fft_valid),
      .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
      .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
      .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
      .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
      .done(done1), .freq(freq1), .busy(busy1), .ovf(ovf1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in;
      fft_valid = 1'b0;
      for (int i = 0; i < 16; i++) d[i] = 'x;
   endtask

   task automatic clear_fr;
      for (int i = 0; i < 16; i++) fr[i] = 32'h0;
   endtask

   task automatic drive_fr;
      fft_valid = 1'b1;
      for (int i = 0; i < 16; i++) d[i] = fr[i];
   endtask

   task automatic set_peak1;
      clear_fr();
      fr[1] = 32'h0100_0000;
   endtask

   task automatic set_peak15;
      clear_fr();
      fr[1]  = 32'h0100_0000;
      fr[15] = 32'h0300_0000;
   endtask

   // Present fr at E0, expect done only at E16 with the given freqs, then idle.
   task automatic run_single(input string tag, input logic [3:0] e0, input logic [3:0] e1);
      drive_fr();
      tick();
      idle_in();
      chk({tag, "_busy"}, busy0, 1);
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk({tag, "_done0"}, done0, (i == 16));
         chk({tag, "_done1"}, done1, (i == 16));
      end
      chk({tag, "_freq0"}, freq0, e0);
      chk({tag, "_freq1"}, freq1, e1);
      tick();
      chk({tag, "_done_clr"}, done0, 0);
      chk({tag, "_idle_busy"}, busy0, 0);
      chk({tag, "_freq_hold"}, freq0, e0);
   endtask

   initial begin
      rst = 1'b0;
      idle_in();
      clear_fr();
      #2 rst = 1'b1;
      tick();
      tick();
      chk("rst_done", done0, 0);
      chk("rst_freq", freq0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_ovf", ovf0, 0);
      chk("rst_busy1", busy1, 0);
      rst = 1'b0;
      tick();

      // Single peak at bin 1, 16-cycle latency.
      set_peak1();
      run_single("single", 4'd1, 4'd1);

      // Equal peaks at bins 1 and 15: lowest index wins.
      for (int i = 0; i < 16; i++) fr[i] = 32'h0001_0001;
      fr[1]  = 32'h0200_0000;
      fr[15] = 32'h0200_0000;
      run_single("tie", 4'd1, 4'd1);

      // Extreme magnitude 2^31 at bin 15 beats near-max at bin 3.
      clear_fr();
      fr[15] = 32'h8000_8000;
      fr[3]  = 32'h7FFF_7FFF;
      run_single("bigmag", 4'd15, 4'd15);

      // DC bin largest: searched by dut0, skipped by dut1.
      clear_fr();
      fr[0] = 32'h7FFF_7FFF;
      fr[2] = 32'h0200_0000;
      fr[5] = 32'h0100_0100;
      run_single("skipdc", 4'd0, 4'd2);

      // All-zero frame: first eligible bin is the answer.
      clear_fr();
      run_single("zeros", 4'd0, 4'd1);

      // Four back-to-back frames 16 cycles apart.
      for (int c = 0; c <= 64; c++) begin
         if (c % 16 == 0 && c < 64) begin
            if ((c / 16) % 2 == 0) set_peak1();
            else set_peak15();
            drive_fr();
         end else begin
            idle_in();
         end
         tick();
         chk("b2b_done", done0, (c >= 16 && c % 16 == 0));
         if (c >= 16 && c % 16 == 0) begin
            chk("b2b_freq0", freq0, ((c / 16) % 2 == 1) ? 4'd1 : 4'd15);
            chk("b2b_freq1", freq1, ((c / 16) % 2 == 1) ? 4'd1 : 4'd15);
         end
      end
      chk("b2b_ovf", ovf0, 0);
      tick();
      chk("b2b_busy", busy0, 0);

      // Frames at E0, E3, E5: E3 frame overwritten by E5.
      for (int c = 0; c <= 50; c++) begin
         if (c == 0) begin
            set_peak1();
            drive_fr();
         end else if (c == 3) begin
            clear_fr();
            fr[5] = 32'h0100_0000;
            drive_fr();
         end else if (c == 5) begin
            clear_fr();
            fr[9] = 32'h0100_0000;
            drive_fr();
         end else begin
            idle_in();
         end
         tick();
         chk("ovw_done", done0, (c == 16 || c == 32));
         if (c == 16) chk("ovw_freqA", freq0, 4'd1);
         if (c == 32) chk("ovw_freqC", freq0, 4'd9);
         chk("ovw_ovf", ovf0, (c >= 5));
         chk("ovw_busy", busy0, (c < 32));
      end

      // Reset mid-scan discards the frame and clears sticky state.
      set_peak1();
      drive_fr();
      tick();
      idle_in();
      for (int c = 1; c <= 7; c++) tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_done", done0, 0);
      chk("mid_rst_freq", freq0, 0);
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_ovf", ovf0, 0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         chk("post_rst_done", done0, 0);
         chk("post_rst_busy", busy0, 0);
      end

      // Fresh frame after reset still works.
      clear_fr();
      fr[7] = 32'hFF00_0200;
      run_single("after_rst", 4'd7, 4'd7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
